// File: rtl/seq_stream_gen.sv
// Serial frame generator: shifts PATTERN out MSB first, with optional repetition,
// zero gaps between frames, abort, and a wrapping count of completed frames.
module seq_stream_gen #(
    parameter int                 PAT_W   = 6,
    parameter logic [PAT_W-1:0]   PATTERN = 6'b101001,
    parameter int                 CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] reps,
    input  logic [2:0]       gap,
    input  logic             abort,
    output logic             Stream,
    output logic             stream_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] Sent
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]   frames_left_q, frames_left_d;
    logic [2:0]         gap_left_q, gap_left_d;
    logic [2:0]         gap_cfg_q, gap_cfg_d;
    logic [CNT_W-1:0]   sent_q, sent_d;
    logic               stream_q, stream_d;
    logic               stream_valid_q, stream_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Next-state and next-output logic; outputs are derived from the next state
    // so the registered outputs line up with the cycle the state is entered.
    always_comb begin
        state_d       = state_q;
        bit_idx_d     = bit_idx_q;
        frames_left_d = frames_left_q;
        gap_left_d    = gap_left_q;
        gap_cfg_d     = gap_cfg_q;
        sent_d        = sent_q;
        done_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && (reps != {CNT_W{1'b0}})) begin
                    frames_left_d = reps;
                    gap_cfg_d     = gap;
                    bit_idx_d     = LAST_IDX;
                    state_d       = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (bit_idx_q != {IDX_W{1'b0}}) begin
                    bit_idx_d = bit_idx_q - IDX_W'(1);
                end else begin
                    sent_d        = sent_q + CNT_W'(1);
                    frames_left_d = frames_left_q - CNT_W'(1);
                    if (frames_left_q == CNT_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else if (gap_cfg_q == 3'd0) begin
                        bit_idx_d = LAST_IDX;
                    end else begin
                        gap_left_d = gap_cfg_q;
                        state_d    = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (gap_left_q <= 3'd1) begin
                    gap_left_d = 3'd0;
                    bit_idx_d  = LAST_IDX;
                    state_d    = S_SHIFT;
                end else begin
                    gap_left_d = gap_left_q - 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_SHIFT) begin
            stream_d       = PATTERN[bit_idx_d];
            stream_valid_d = 1'b1;
        end else begin
            stream_d       = 1'b0;
            stream_valid_d = 1'b0;
        end
        busy_d = (state_d != S_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            bit_idx_q      <= {IDX_W{1'b0}};
            frames_left_q  <= {CNT_W{1'b0}};
            gap_left_q     <= 3'd0;
            gap_cfg_q      <= 3'd0;
            sent_q         <= {CNT_W{1'b0}};
            stream_q       <= 1'b0;
            stream_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_idx_q      <= bit_idx_d;
            frames_left_q  <= frames_left_d;
            gap_left_q     <= gap_left_d;
            gap_cfg_q      <= gap_cfg_d;
            sent_q         <= sent_d;
            stream_q       <= stream_d;
            stream_valid_q <= stream_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign Stream       = stream_q;
    assign stream_valid = stream_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign Sent         = sent_q;

endmodule

// File: tb/tb_seq_stream_gen.sv
// Directed bench for seq_stream_gen: cycle vectors from a table, plus reset,
// counter wrap and a loopback into a reference 101001 detector.
module tb_seq_stream_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] reps;
    logic [2:0] gap;
    logic       Stream;
    logic       stream_valid;
    logic       busy;
    logic       done;
    logic [3:0] Sent;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       start;
        logic [3:0] reps;
        logic [2:0] gap;
        logic       abort;
        logic       stream;
        logic       valid;
        logic       busy;
        logic       done;
        logic [3:0] sent;
    } vec_t;

    vec_t vecs[$];
    int   vec_no = 0;

    logic [4:0] det_sr;
    int         det_cnt;

    seq_stream_gen dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .reps         (reps),
        .gap          (gap),
        .abort        (abort),
        .Stream       (Stream),
        .stream_valid (stream_valid),
        .busy         (busy),
        .done         (done),
        .Sent         (Sent)
    );

    always #5 clk = ~clk;

    // reference detector listening on the generated stream
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            det_sr  <= 5'd0;
            det_cnt <= 0;
        end else begin
            det_sr <= {det_sr[3:0], Stream};
            if ({det_sr, Stream} == 6'b101001) det_cnt <= det_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic add(input logic st, input logic [3:0] r, input logic [2:0] g, input logic ab,
                       input logic s, input logic v, input logic b, input logic d, input logic [3:0] sn);
        vec_t e;
        e = '{st, r, g, ab, s, v, b, d, sn};
        vecs.push_back(e);
    endtask

    // six vectors covering one frame of 101001; only the first may carry start/abort
    task automatic add_frame(input logic st0, input logic st_rest, input logic [3:0] r0,
                             input logic [3:0] r_rest, input logic [2:0] g, input logic ab0,
                             input logic [3:0] sn);
        logic [5:0] pat;
        pat = 6'b101001;
        for (int i = 0; i < 6; i++) begin
            add((i == 0) ? st0 : st_rest, (i == 0) ? r0 : r_rest, g, (i == 0) ? ab0 : 1'b0,
                pat[5-i], 1'b1, 1'b1, 1'b0, sn);
        end
    endtask

    task automatic run_vecs();
        vec_t v;
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            start = v.start;
            reps  = v.reps;
            gap   = v.gap;
            abort = v.abort;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", vec_no), {8'd0, Stream, stream_valid, busy, done, Sent},
                  {8'd0, v.stream, v.valid, v.busy, v.done, v.sent});
            vec_no++;
        end
        vecs.delete();
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, {15'd0, done}, 16'd1);
    endtask

    initial begin
        logic [3:0] sn;
        rst = 1'b1; start = 1'b0; abort = 1'b0; reps = 4'd0; gap = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", {8'd0, Stream, stream_valid, busy, done, Sent}, 16'd0);
        rst = 1'b0;

        // single frame
        add_frame(1'b1, 1'b0, 4'd1, 4'd0, 3'd0, 1'b0, 4'd0);
        add(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
        add(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        // two frames back to back
        add_frame(1'b1, 1'b0, 4'd2, 4'd0, 3'd0, 1'b0, 4'd1);
        add_frame(1'b0, 1'b0, 4'd0, 4'd0, 3'd0, 1'b0, 4'd2);
        add(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
        add(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
        // two frames with a two-cycle gap
        add_frame(1'b1, 1'b0, 4'd2, 4'd0, 3'd2, 1'b0, 4'd3);
        add(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd4);
        add(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd4);
        add_frame(1'b0, 1'b0, 4'd0, 4'd0, 3'd0, 1'b0, 4'd4);
        add(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
        add(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5);
        // reps=0 is ignored
        add(1'b1, 4'd0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5);
        add(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5);
        // start held while busy is ignored; start in the done cycle restarts
        add_frame(1'b1, 1'b1, 4'd1, 4'd7, 3'd0, 1'b0, 4'd5);
        add(1'b1, 4'd7, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd6);
        add_frame(1'b1, 1'b0, 4'd1, 4'd0, 3'd0, 1'b0, 4'd6);
        add(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7);
        add(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7);
        // abort during bit 3 of frame 1
        add(1'b1, 4'd2, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd7);
        add(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd7);
        add(1'b0, 4'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd7);
        add(1'b0, 4'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7);
        add(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7);
        add(1'b0, 4'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7);
        // start and abort together in idle: start wins
        add_frame(1'b1, 1'b0, 4'd1, 4'd0, 3'd0, 1'b1, 4'd7);
        add(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8);
        // abort inside a gap
        add_frame(1'b1, 1'b0, 4'd3, 4'd0, 3'd2, 1'b0, 4'd8);
        add(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd9);
        add(1'b0, 4'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9);
        add(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9);
        add(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9);
        run_vecs();

        // counter wrap: seven more frames take Sent from 9 through 15 to 0
        sn = 4'd9;
        for (int k = 0; k < 7; k++) begin
            add_frame(1'b1, 1'b0, 4'd1, 4'd0, 3'd0, 1'b0, sn);
            sn = sn + 4'd1;
            add(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, sn);
        end
        run_vecs();
        check("sent_wrap", {12'd0, Sent}, 16'd0);

        // asynchronous reset in the middle of a frame
        add_frame(1'b1, 1'b0, 4'd2, 4'd0, 3'd0, 1'b0, 4'd0);
        void'(vecs.pop_back());
        void'(vecs.pop_back());
        void'(vecs.pop_back());
        run_vecs();
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", {8'd0, Stream, stream_valid, busy, done, Sent}, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) add(1'b0, 4'd5, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        run_vecs();

        // loopback into the reference detector
        start = 1'b1; reps = 4'd3; gap = 3'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("loop_done1");
        start = 1'b1; reps = 4'd2; gap = 3'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("loop_done2");
        repeat (2) @(posedge clk);
        #1;
        check("loop_sent", {12'd0, Sent}, 16'd5);
        check("loop_detect", det_cnt[15:0], 16'd5);
        check("detect_eq_sent", det_cnt[15:0], {12'd0, Sent});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_stream_gen.md
# seq_stream_gen

Serial pattern generator that drives the 6-bit framing sequence 101001 onto a single-bit stream, MSB first, one bit per clock. It is the transmit side of the sequence-detector path: its `Stream` output feeds the detector's `Stream` input directly, and each completed frame should produce exactly one detection there. It supports a programmable repetition count, inter-frame zero gaps, abort, and a running count of frames sent.

## Interface
- `PATTERN`, default 6'b101001: bit sequence transmitted, MSB first.
- `PAT_W`, default 6: pattern width; legal range 2..16.
- `CNT_W`, default 4: width of `Sent` and `reps`.
- `clk` input, 1 bit: single clock, rising-edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `start` input, 1 bit: request to transmit; sampled on the rising edge of `clk`.
- `reps` input, `CNT_W` bits: number of frames to send; sampled when `start` is accepted.
- `gap` input, 3 bits: number of zero cycles inserted between frames; sampled when `start` is accepted.
- `abort` input, 1 bit: synchronous cancel of the transfer in progress.
- `Stream` output, 1 bit: serial data, registered.
- `stream_valid` output, 1 bit: high while `Stream` carries a pattern bit.
- `busy` output, 1 bit: high while a transfer is in progress.
- `done` output, 1 bit: one-cycle pulse when a transfer completes normally.
- `Sent` output, `CNT_W` bits: count of completed frames since reset; wraps.

## Operation
- **States:** IDLE, SHIFT, GAP. Stored registers are:
  - `bit_idx`: `$clog2(PAT_W)` bits.
  - `frames_left`: `CNT_W` bits.
  - `gap_left`: 3 bits.
  - `gap_cfg`: 3 bits.
- **Reset (async, any state):**
  - The FSM goes to IDLE.
  - `Stream`, `stream_valid`, `busy`, `done` and `Sent` all become 0.
  - `bit_idx`, `frames_left` and `gap_left` become 0.
- **IDLE:**
  - Outputs: `Stream`=0, `stream_valid`=0, `busy`=0.
  - When `start`=1 and `reps`≠0:
    - Latch `frames_left`=`reps`, `gap_cfg`=`gap`, `bit_idx`=`PAT_W`-1.
    - Go to SHIFT.
  - When `start`=1 and `reps`=0: ignore the request. No `busy`, no `done`.
- **SHIFT:**
  - Each cycle drive `Stream`=`PATTERN[bit_idx]`, `stream_valid`=1, `busy`=1.
  - While `bit_idx`>0: decrement `bit_idx`.
  - On the last bit (`bit_idx`=0):
    - `Sent` increments and `frames_left` decrements, both at the edge that ends that bit.
    - If `frames_left` becomes 0: go to IDLE and pulse `done` for the following cycle.
    - Else, if `gap_cfg`=0: reload `bit_idx`=`PAT_W`-1 and stay in SHIFT (back-to-back frames).
    - Else: load `gap_left`=`gap_cfg` and go to GAP.
- **GAP:**
  - Outputs: `Stream`=0, `stream_valid`=0, `busy`=1.
  - Decrement `gap_left`. When it reaches 1, the next cycle enters SHIFT with `bit_idx`=`PAT_W`-1.
- **`start` while `busy`=1:** ignored. No queuing, and latched `reps`/`gap` are unchanged.
- **`start` in the `done` cycle:** accepted, because the FSM is already in IDLE.
- **`abort`:**
  - When sampled high in SHIFT or GAP, the next cycle is IDLE with `Stream`=0, `stream_valid`=0, `busy`=0.
  - `done` is not pulsed.
  - A partial frame does not increment `Sent`.
  - `abort` in IDLE has no effect.
  - `abort` and `start` together in IDLE: `start` wins.
- **Arithmetic:** `Sent` is a modulo-2^`CNT_W` counter (15→0 at `CNT_W`=4). `frames_left` never underflows, because `reps`=0 is rejected.

## Timing
- **Start latency:** `start` sampled at edge k → first pattern bit on `Stream` during cycle k+1 (from edge k to edge k+1).
- **Frame length:** exactly `PAT_W` cycles, with no bubbles inside a frame.
- **`done` timing:** `done` is high for the single cycle after the last bit of the last frame. `busy` is already 0 in that cycle.
- **Transfer length:** a transfer occupies `reps`·`PAT_W` + (`reps`-1)·`gap` busy cycles.
- **`Sent` timing:** `Sent` updates are visible one cycle after the final bit of each frame.
- **Output registers:** all outputs are registered, so there is no combinational path from inputs to outputs.

## Test plan
- **Reset:** assert `rst` mid-frame → all outputs 0 immediately, before the next edge. After release, the FSM stays idle until `start`.
- **Single frame:** `reps`=1, `gap`=0, `start` at edge k → `Stream` = 1,0,1,0,0,1 in cycles k+1..k+6, `stream_valid`=1 for those six cycles, `done` in k+7, `Sent`=1.
- **Back-to-back with gap:**
  - `reps`=2, `gap`=0 → 12 contiguous valid bits, `done` at k+13, `Sent`=2.
  - `reps`=2, `gap`=2 → zeros in k+7..k+8, second frame in k+9..k+14, `done` at k+15.
- **Abort and ignored starts:**
  - `abort` during bit 3 of frame 1 → `busy`=0 next cycle, no `done`, `Sent` unchanged.
  - `start` pulsed while busy → no effect.
  - `reps`=0 → no activity.
- **Counter wrap:** 16 single-frame transfers → `Sent` returns to 0.
- **Restart on `done`:** `start` asserted in the `done` cycle → a new frame begins the next cycle.
- **Loopback:** drive the detector's `Stream` input from this block → each frame produces one detection. The detector's count must equal `Sent`.
